// File: rtl/rf_pkg.sv
// rf_pkg: shared widths, register counts and port-slice helpers for the multi-port register file
package rf_pkg;
    localparam int RF_ADDR_W  = 5;
    localparam int RV32E_NREG = 16;
    localparam int RV32I_NREG = 32;

    typedef logic [RF_ADDR_W-1:0] rf_addr_t;

    function automatic logic rf_legal(input rf_addr_t addr, input int nreg);
        return int'(addr) < nreg;
    endfunction

    function automatic int rf_addr_lsb(input int port);
        return RF_ADDR_W * port;
    endfunction

    function automatic int rf_data_lsb(input int port, input int xlen);
        return xlen * port;
    endfunction
endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register busy bits, set by decode and cleared by writeback
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = RV32E_NREG,
    parameter int NWR  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            sb_set,
    input  rf_addr_t        sb_addr,
    input  logic [NWR-1:0]  wen,
    input  rf_addr_t        rd_a [NWR],
    output logic [NREG-1:0] busy_nxt
);
    logic [NREG-1:0] busy;

    // x0 is never tracked; a new producer overrides a same-edge writeback
    always_comb begin
        busy_nxt = busy;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++)
                if (wen[j] && int'(rd_a[j]) == r) busy_nxt[r] = 1'b0;
            if (sb_set && int'(sb_addr) == r) busy_nxt[r] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) busy <= '0;
        else if (en) busy <= busy_nxt;
endmodule

// File: rtl/register_file_mp.sv
// register_file_mp: multi-port integer register file with write-first bypass, busy scoreboard and illegal-access report
module register_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = RV32E_NREG,
    parameter int NRD  = 2,
    parameter int NWR  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rf_en,
    input  logic [NRD*5-1:0]    rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    input  logic [NWR-1:0]      wen,
    input  logic [NWR*5-1:0]    rd_addr,
    input  logic [NWR*XLEN-1:0] rd_data,
    input  logic                sb_set,
    input  logic [4:0]          sb_addr,
    output logic                exc_valid,
    output logic [4:0]          exc_addr
);
    localparam int AW = $clog2(NREG);

    rf_addr_t        rs_a [NRD];
    rf_addr_t        rd_a [NWR];
    logic [XLEN-1:0] wd [NWR];
    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] rd_val [NRD];
    logic [NRD-1:0]  busy_val;
    logic [NREG-1:0] busy_nxt;
    logic            ill;
    rf_addr_t        ill_addr;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        assign rs_a[i] = rs_addr[rf_addr_lsb(i) +: RF_ADDR_W];
    end
    for (genvar j = 0; j < NWR; j++) begin : g_wr
        assign rd_a[j] = rd_addr[rf_addr_lsb(j) +: RF_ADDR_W];
        assign wd[j]   = rd_data[rf_data_lsb(j, XLEN) +: XLEN];
    end

    rf_scoreboard #(.NREG(NREG), .NWR(NWR)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (rf_en),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .wen      (wen),
        .rd_a     (rd_a),
        .busy_nxt (busy_nxt)
    );

    // Later (higher-index) writes overwrite earlier ones, giving both write-first bypass and port priority
    always_comb begin
        ill      = 1'b0;
        ill_addr = '0;
        for (int j = 0; j < NWR; j++)
            if (wen[j] && !rf_legal(rd_a[j], NREG) && !ill) begin
                ill      = 1'b1;
                ill_addr = rd_a[j];
            end
        for (int i = 0; i < NRD; i++)
            if (!rf_legal(rs_a[i], NREG) && !ill) begin
                ill      = 1'b1;
                ill_addr = rs_a[i];
            end
        for (int i = 0; i < NRD; i++) begin
            rd_val[i]   = regs[rs_a[i][AW-1:0]];
            busy_val[i] = busy_nxt[rs_a[i][AW-1:0]];
            for (int j = 0; j < NWR; j++)
                if (wen[j] && rd_a[j] == rs_a[i]) rd_val[i] = wd[j];
            if (!rf_legal(rs_a[i], NREG) || rs_a[i] == '0) begin
                rd_val[i]   = '0;
                busy_val[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) regs[r] <= '0;
            rs_data   <= '0;
            rs_busy   <= '0;
            exc_valid <= 1'b0;
            exc_addr  <= '0;
        end else begin
            exc_valid <= rf_en && ill;
            if (rf_en) begin
                for (int j = 0; j < NWR; j++)
                    if (wen[j] && rf_legal(rd_a[j], NREG) && rd_a[j] != '0) regs[rd_a[j][AW-1:0]] <= wd[j];
                for (int i = 0; i < NRD; i++) begin
                    rs_data[rf_data_lsb(i, XLEN) +: XLEN] <= rd_val[i];
                    rs_busy[i] <= busy_val[i];
                end
                if (ill) exc_addr <= ill_addr;
            end
        end
endmodule

// File: doc/register_file_mp.md
Name: register_file_mp

Overview:
Parametrised multi-port integer register file, successor to the single-port RV32E file. Supports RV32E (16 regs) or RV32I (32 regs), NRD registered read ports and NWR write ports. Adds write-to-read bypass, a per-register busy scoreboard for the pipelined and multicore cores, and a registered illegal-access report. Sits between decode (read/scoreboard-set) and writeback (write/scoreboard-clear).

Parameters:
XLEN, 32, data width in bits
NREG, 16, implemented registers; legal values 16 or 32
NRD, 2, read ports; legal range 1..4
NWR, 1, write ports; legal range 1..2

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
rf_en  in  1  block enable; low = no writes, no scoreboard update, outputs hold
rs_addr  in  NRD*5  read addresses, port i at [5i+4:5i]
rs_data  out  NRD*XLEN  read data, port i at [XLEN*i +: XLEN]
rs_busy  out  NRD  scoreboard busy bit of each read register
wen  in  NWR  write enables
rd_addr  in  NWR*5  write addresses
rd_data  in  NWR*XLEN  write data
sb_set  in  1  mark register sb_addr busy (decode issued a producer)
sb_addr  in  5  register to mark busy
exc_valid  out  1  one-cycle pulse: illegal access last cycle
exc_addr  out  5  first offending address (priority: write ports low→high, then read ports low→high)

Behaviour:
- Reset (async, rst_n=0): all registers 0, all busy bits 0, rs_data=0, rs_busy=0, exc_valid=0, exc_addr=0. Reset mid-write discards the write.
- All inputs are sampled only on a rising clk edge with rf_en=1. rf_en=0: state and outputs frozen; exc_valid driven 0.
- Read latency is 1 cycle. rs_data[i] holds the value of rs_addr[i] sampled at the edge, and stays until the next enabled edge.
- Bypass: a same-edge write to the read address is visible on rs_data in that same update (write-first).
- x0 reads always return 0 and busy 0. Writes to x0 and sb_set to x0 are ignored.
- Write conflict: two write ports target the same address in one edge → the higher-index port wins.
- Legal address: addr < NREG. Illegal write: dropped. Illegal read: rs_data=0, rs_busy=0. Illegal sb_addr: ignored.
- Any illegal access at an enabled edge sets exc_valid=1 for exactly the next cycle, with exc_addr per the priority rule. Otherwise exc_valid=0.
- Scoreboard, per register r at an enabled edge:
  - busy[r] ← 1 if sb_set && sb_addr==r.
  - Else busy[r] ← 0 if any wen hits r.
  - Else busy[r] holds.
  - Set beats clear when both occur in the same edge (new producer supersedes).
- rs_busy reflects the post-update scoreboard, consistent with the bypass.
- X on inputs is not filtered. Callers must drive defined values while rf_en=1.

Decomposition:
- Package rf_pkg holds:
  - RF_ADDR_W=5
  - RV32E_NREG=16, RV32I_NREG=32
  - typedef rf_addr_t
  - function rf_legal(addr, nreg)
  - port-slice helper functions
- Sub-module rf_scoreboard: NREG busy bits with set/clear/priority logic, instantiated once.

Test Plan:
- Reset, then read x1..x15 on 2 ports → all 0, rs_busy=0, exc_valid=0.
- Write x5=0xDEADBEEF and read x5 in the same edge → rs_data[0]=0xDEADBEEF one cycle later. Write x0=0x1234, then read x0 → 0.
- NWR=2, both ports write x7 (0x11, 0x22) → x7 reads 0x22.
- NREG=16: write x20=0xAA, read x17 → next cycle exc_valid=1 for one cycle, exc_addr=20; rs_data for x17=0; no register changed.
- Scoreboard sequence:
  - sb_set x3 → rs_busy=1 on a read of x3.
  - Write x3 → busy 0.
  - sb_set x3 and write x3 in the same edge → busy stays 1 and data updates.
- rf_en=0 with wen=1 and sb_set=1 → no state change, outputs hold. Assert rst_n low mid-cycle → all outputs 0 immediately, before the next clk edge.
